// File: rtl/sw_debounce_pkg.sv
// Shared constants for the slide-switch debouncer; the top level and the
// bench pick their debounce timing from here.
package sw_debounce_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;
    localparam int unsigned DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchroniser, stable-time counter, debounced level
// flop and registered rise/fall strobes.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == db) begin
                // Any return to the accepted level discards the partial count.
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db   <= sync2;
                cnt  <= '0;
                rise <= sync2;
                fall <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces the raw slide switches for the top_mux select and produces
// per-bit change strobes plus a combined any-change strobe.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_chg
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .raw (sw_raw[i]),
            .db  (sw_db[i]),
            .rise(sw_rise[i]),
            .fall(sw_fall[i])
        );
    end

    // Built only from registered strobes, so still no path from sw_raw.
    always_comb begin
        sw_chg = |(sw_rise | sw_fall);
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with short simulation timing: expected outputs are
// queued as each cycle's stimulus is driven and checked after the edge.
module tb_sw_debounce;
    import sw_debounce_pkg::*;

    localparam int unsigned W   = 4;
    localparam int unsigned LAT = SIM_DEBOUNCE_CYCLES + 2;

    typedef struct packed {
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    typedef struct {
        logic [W-1:0] raw;
        exp_t         e;
    } vec_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_chg;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    string        phase   = "init";
    logic [W-1:0] cur_db  = '0;

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .CNT_W          (3)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (sw_raw),
        .sw_db  (sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_chg (sw_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [W-1:0] db, input logic [W-1:0] rise,
                                input logic [W-1:0] fall, input logic chg);
        exp_t e;
        e.db = db; e.rise = rise; e.fall = fall; e.chg = chg;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        exp_t a;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got output with no expectation", phase);
            return;
        end
        e = sb.pop_front();
        a = mk(sw_db, sw_rise, sw_fall, sw_chg);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got db=%h rise=%h fall=%h chg=%b, required db=%h rise=%h fall=%h chg=%b",
                     phase, $time, a.db, a.rise, a.fall, a.chg, e.db, e.rise, e.fall, e.chg);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check after the edge.
    task automatic drive_cycle(input logic [W-1:0] raw, input exp_t e);
        sw_raw = raw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Hold a value n cycles; sw_db takes it LAT edges after it is applied.
    task automatic hold(input logic [W-1:0] v, input int unsigned n);
        for (int unsigned k = 1; k <= n; k++) begin
            if (k < LAT)
                drive_cycle(v, mk(cur_db, '0, '0, 1'b0));
            else if (k == LAT)
                drive_cycle(v, mk(v, v & ~cur_db, cur_db & ~v, v != cur_db));
            else
                drive_cycle(v, mk(v, '0, '0, 1'b0));
        end
        if (n >= LAT) cur_db = v;
    endtask

    vec_t bounce[12];

    initial begin
        for (int i = 0; i < 12; i++) bounce[i].e = mk('0, '0, '0, 1'b0);
        bounce[0].raw  = 4'h1; bounce[1].raw  = 4'h1; bounce[2].raw  = 4'h1;
        bounce[3].raw  = 4'h0;
        bounce[4].raw  = 4'h1; bounce[5].raw  = 4'h1; bounce[6].raw  = 4'h1;
        bounce[7].raw  = 4'h0; bounce[8].raw  = 4'h0; bounce[9].raw  = 4'h0;
        bounce[10].raw = 4'h0; bounce[11].raw = 4'h0;

        rst    = 1'b1;
        sw_raw = 4'hF;

        phase = "reset_hold";
        for (int i = 0; i < 3; i++) drive_cycle(4'hF, mk('0, '0, '0, 1'b0));
        rst = 1'b0;
        cur_db = '0;
        phase = "reset_release_rise";
        hold(4'hF, 8);

        phase = "all_fall";
        hold(4'h0, 8);

        phase = "bounce";
        foreach (bounce[i]) drive_cycle(bounce[i].raw, bounce[i].e);

        phase = "rise_3";
        hold(4'h3, 8);

        phase = "setup_5";
        hold(4'h5, 8);
        phase = "mixed_5_to_A";
        hold(4'hA, 8);

        for (int v = 0; v < 16; v++) begin
            phase = $sformatf("sweep_%0h", v);
            hold(4'(v), 10);
        end
        phase = "sweep_repeat_F";
        hold(4'hF, 10);

        phase = "setup_1";
        hold(4'h1, 8);
        phase = "partial_count_bit2";
        hold(4'h5, 4);
        rst = 1'b1;
        #1;
        phase = "reset_async_clear";
        sb.push_back(mk('0, '0, '0, 1'b0));
        check_out();
        drive_cycle(4'h5, mk('0, '0, '0, 1'b0));
        rst = 1'b0;
        cur_db = '0;
        phase = "rise_after_midcount_reset";
        hold(4'h5, 8);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Conditions the raw board slide switches before they reach the top_mux select input. The mux stage consumes sw_db[3:0] as its sw[3:0].
- Per bit: a 2-flop synchroniser, then a stable-time counter debouncer, then a registered edge detector.
- Gives the mux a glitch-free select. Also gives single-cycle change strobes for downstream counters and display logic.

Parameters:
- WIDTH, 4: number of switch bits debounced.
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised bit must differ from its debounced value before it is accepted. 10 ms at 50 MHz. Legal range 2..2^CNT_W-1.
- CNT_W, 20: width of each per-bit stability counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears all state immediately.
- sw_raw  in  WIDTH  raw switch pins; asynchronous to clk and bouncy.
- sw_db  out  WIDTH  debounced level; feeds top_mux sw.
- sw_rise  out  WIDTH  one-cycle pulse per bit when sw_db bit goes 0->1.
- sw_fall  out  WIDTH  one-cycle pulse per bit when sw_db bit goes 1->0.
- sw_chg  out  1  one-cycle pulse when any sw_db bit changes (OR of sw_rise|sw_fall).

Behaviour:
- Reset (async, rst=1): sync1, sync2, sw_db, counters, sw_rise, sw_fall and sw_chg all go to 0 immediately. They stay 0 while rst is held.
- Synchroniser: on each edge, sync1<=sw_raw and sync2<=sync1. Only sync2 is used downstream.
- Per-bit debounce, evaluated each edge, all bits independent:
  - If sync2[i]==sw_db[i]: cnt[i]<=0 and no pulse.
  - If they differ and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
  - If they differ and cnt[i]==DEBOUNCE_CYCLES-1: sw_db[i]<=sync2[i], cnt[i]<=0, and the matching rise/fall bit is 1 for exactly that cycle.
- Per-bit state machine is implicit, two states:
  - STABLE (cnt=0, match) goes to COUNTING on mismatch.
  - COUNTING goes back to STABLE on match, which discards the partial count.
  - COUNTING goes to STABLE with sw_db toggled when the count completes.
- Latency: a raw level held steady from before edge 1, where edge 1 is the first edge that samples it:
  - sync2 shows the new level after edge 2.
  - sw_db changes after edge DEBOUNCE_CYCLES+2.
  - The pulse is visible in the cycle following that edge.
- Bounce rejection: any return to the old level before the count completes resets the counter to 0. A run of DEBOUNCE_CYCLES-1 or fewer mismatching sync2 samples never changes sw_db.
- Pulses:
  - sw_rise, sw_fall and sw_chg are registered, so there are no combinational paths from sw_raw.
  - They are high for exactly one cycle per accepted transition.
  - sw_rise[i] and sw_fall[i] are never high together.
- Simultaneous bits: several bits completing on the same edge give several rise/fall bits set that cycle and a single sw_chg pulse.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-count: the partial count is lost and sw_db returns to 0. If the pins are high when rst deasserts, sw_db[i] rises DEBOUNCE_CYCLES+2 edges later with a sw_rise pulse.
- Reset deassertion is not synchronised inside this block. The top level provides a release synchronised to clk.

Decomposition:
- Shared package: DEFAULT_DEBOUNCE_CYCLES (500000), SIM_DEBOUNCE_CYCLES (4), DEFAULT_CNT_W (20). The testbench and top-level share these.
- Sub-module debounce_bit: one bit's synchroniser, counter, debounced flop and rise/fall pulse.
- sw_debounce instantiates WIDTH copies with a generate loop and ORs the pulses into sw_chg.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
1. Assert rst with sw_raw=4'hF, then release rst and hold 4'hF. -> sw_db=0 during reset. sw_db=4'hF after edge 6. sw_rise=4'hF and sw_chg=1 for one cycle only.
2. From sw_db=4'h0, set sw_raw=4'h3 and hold. -> sw_db stays 0 through edge 5, becomes 4'h3 after edge 6. sw_rise=4'h3 for one cycle and sw_fall=0.
3. Bounce: toggle sw_raw[0] 0->1 for 3 cycles, 0 for 1 cycle, 1 for 3 cycles, then 0. -> sw_db[0] never changes and no pulses occur.
4. Sweep sw_raw 4'h0..4'hF, holding each value 10 cycles (mirrors the mux bench). -> sw_db follows each value 6 edges after it is applied. sw_chg pulses once per value change. No pulse when the value repeats.
5. Mixed edges on one edge: sw_db=4'h5, set sw_raw=4'hA. -> after 6 edges sw_db=4'hA, sw_rise=4'hA, sw_fall=4'h5, and a single sw_chg pulse.
6. Pulse rst for 1 cycle while bit 2 has reached count 2. -> sw_db=0 immediately and the count is cleared. With sw_raw held, sw_db[2] returns 6 edges after release.
